fetch_seq: RTL and testbench

- Owns the fetch-stage PC register and sequences instruction memory through a req/ack handshake with variable latency.
- Each cycle it selects the next PC: sequential/branch/jump `npc` from the next-PC logic, the exception handler on `trap`, or `epc` on `eret`.
- Handles hazard stalls and redirects. A redirect never abandons an outstanding imem request: the old request is drained and its data discarded.
- Checks fetch addresses and raises AdEL for misaligned or out-of-range PCs.

---
 rtl/fetch_seq.sv | 143 ++++++++++++++
 tb/tb_fetch_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// Fetch-stage sequencer: owns pcF, issues imem requests through a req/ack
// handshake, holds the fetched word across hazard stalls, and drains any
// outstanding request when a trap/eret redirect arrives mid-flight.
//
// state | meaning
// REQ   | pcF is presented to imem (or flagged AdEL if illegal), waiting on ack
// HOLD  | instruction for pcF already fetched, held in ibuf while D is stalled
// DRAIN | redirect arrived with a request in flight; finish it and drop data
module fetch_seq #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        trap,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        validF,
  output logic        adelF,
  output logic        flushF
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] ibuf, ibuf_n;
  logic [31:0] drain_addr, drain_addr_n;
  logic [31:0] pc_n;

  logic        redirect;
  logic [31:0] tgt;
  logic        bad;

  assign redirect = trap | eret;
  assign tgt      = eret ? epc : HANDLER_PC;
  assign bad      = (pcF[1:0] != 2'b00) | (pcF < IMEM_LO) | (pcF > IMEM_HI);

  // State and datapath registers; reset returns to a clean REQ at RESET_PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= REQ;
      pcF        <= RESET_PC;
      ibuf       <= 32'h0;
      drain_addr <= 32'h0;
    end else begin
      state      <= state_n;
      pcF        <= pc_n;
      ibuf       <= ibuf_n;
      drain_addr <= drain_addr_n;
    end
  end

  // Next-state, next-PC and all handshake/stage outputs; outputs are held
  // quiet while reset is asserted.
  always_comb begin
    state_n      = state;
    pc_n         = pcF;
    ibuf_n       = ibuf;
    drain_addr_n = drain_addr;
    imem_req     = 1'b0;
    imem_addr    = 32'h0;
    instrF       = 32'h0;
    validF       = 1'b0;
    adelF        = 1'b0;
    flushF       = 1'b0;

    if (!reset) begin
      flushF = redirect;
      unique case (state)
        REQ: begin
          if (bad) begin
            // Illegal PC: never reaches memory, reported as AdEL in place.
            if (redirect) begin
              pc_n = tgt;
            end else begin
              validF = 1'b1;
              adelF  = 1'b1;
              if (!stall) pc_n = npc;
            end
          end else begin
            imem_req  = 1'b1;
            imem_addr = pcF;
            if (redirect) begin
              pc_n = tgt;
              if (!imem_ack) begin
                // Request must finish at its original address before the
                // target can be fetched.
                drain_addr_n = pcF;
                state_n      = DRAIN;
              end
            end else if (imem_ack) begin
              validF = 1'b1;
              instrF = imem_rdata;
              ibuf_n = imem_rdata;
              if (!stall) pc_n = npc;
              else        state_n = HOLD;
            end
          end
        end

        HOLD: begin
          if (redirect) begin
            pc_n    = tgt;
            state_n = REQ;
          end else begin
            validF = 1'b1;
            instrF = ibuf;
            if (!stall) begin
              pc_n    = npc;
              state_n = REQ;
            end
          end
        end

        DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = drain_addr;
          if (redirect) pc_n = tgt;
          if (imem_ack) state_n = REQ;
        end

        default: begin
          state_n = REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: drives one vector per cycle shortly after the
// rising edge and checks the combinational outputs mid-cycle.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic        trap;
  logic        eret;
  logic [31:0] epc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        validF;
  logic        adelF;
  logic        flushF;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_seq dut (
    .clk        (clk),
    .reset      (reset),
    .npc        (npc),
    .stall      (stall),
    .trap       (trap),
    .eret       (eret),
    .epc        (epc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pcF        (pcF),
    .instrF     (instrF),
    .validF     (validF),
    .adelF      (adelF),
    .flushF     (flushF)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Apply one cycle's inputs just after the edge, then settle to mid-cycle.
  task automatic drive(input logic a, input logic [31:0] rd, input logic [31:0] n,
                       input logic st, input logic tr, input logic er,
                       input logic [31:0] ep);
    imem_ack   = a;
    imem_rdata = rd;
    npc        = n;
    stall      = st;
    trap       = tr;
    eret       = er;
    epc        = ep;
    #3;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    tick;
    // reset: outputs quiet even with trap asserted
    drive(0, 32'h0, 32'h0, 0, 1, 0, 32'h0);
    chk("rst_req",   32'(imem_req), 0);
    chk("rst_valid", 32'(validF), 0);
    chk("rst_flush", 32'(flushF), 0);
    chk("rst_pc",    pcF, 32'h3000);
    tick;
    reset = 1'b0;

    // zero-wait back-to-back fetch
    drive(1, 32'h1111_3000, 32'h3004, 0, 0, 0, 32'h0);
    chk("zw0_req",   32'(imem_req), 1);
    chk("zw0_addr",  imem_addr, 32'h3000);
    chk("zw0_valid", 32'(validF), 1);
    chk("zw0_instr", instrF, 32'h1111_3000);
    tick;
    drive(1, 32'h1111_3004, 32'h3008, 0, 0, 0, 32'h0);
    chk("zw1_addr",  imem_addr, 32'h3004);
    chk("zw1_valid", 32'(validF), 1);
    tick;
    drive(1, 32'h1111_3008, 32'h300C, 0, 0, 0, 32'h0);
    chk("zw2_addr",  imem_addr, 32'h3008);
    chk("zw2_instr", instrF, 32'h1111_3008);
    tick;

    // ack after 3 cycles at 0x300C
    drive(0, 32'hDEAD_0000, 32'h3010, 0, 0, 0, 32'h0);
    chk("lat0_addr",  imem_addr, 32'h300C);
    chk("lat0_valid", 32'(validF), 0);
    tick;
    drive(0, 32'hDEAD_0001, 32'h3010, 0, 0, 0, 32'h0);
    chk("lat1_pc",    pcF, 32'h300C);
    chk("lat1_valid", 32'(validF), 0);
    chk("lat1_addr",  imem_addr, 32'h300C);
    tick;
    drive(1, 32'h2222_300C, 32'h3010, 0, 0, 0, 32'h0);
    chk("lat2_pc",    pcF, 32'h300C);
    chk("lat2_valid", 32'(validF), 1);
    chk("lat2_instr", instrF, 32'h2222_300C);
    tick;

    // ack with stall -> HOLD for two cycles
    drive(1, 32'h3333_3010, 32'h3014, 1, 0, 0, 32'h0);
    chk("st0_pc",    pcF, 32'h3010);
    chk("st0_instr", instrF, 32'h3333_3010);
    tick;
    drive(0, 32'hDEAD_BEEF, 32'h3014, 1, 0, 0, 32'h0);
    chk("hold0_req",   32'(imem_req), 0);
    chk("hold0_addr",  imem_addr, 32'h0);
    chk("hold0_valid", 32'(validF), 1);
    chk("hold0_instr", instrF, 32'h3333_3010);
    chk("hold0_pc",    pcF, 32'h3010);
    tick;
    drive(0, 32'hDEAD_BEEF, 32'h3014, 0, 0, 0, 32'h0);
    chk("hold1_instr", instrF, 32'h3333_3010);
    chk("hold1_req",   32'(imem_req), 0);
    tick;

    // trap with request outstanding -> DRAIN old address
    drive(0, 32'h0, 32'h3018, 0, 1, 0, 32'h0);
    chk("tr_pc",    pcF, 32'h3014);
    chk("tr_flush", 32'(flushF), 1);
    chk("tr_valid", 32'(validF), 0);
    chk("tr_addr",  imem_addr, 32'h3014);
    tick;
    drive(0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    chk("dr0_pc",    pcF, 32'h4180);
    chk("dr0_req",   32'(imem_req), 1);
    chk("dr0_addr",  imem_addr, 32'h3014);
    chk("dr0_valid", 32'(validF), 0);
    tick;
    drive(1, 32'hBAD0_BAD0, 32'h0, 0, 0, 0, 32'h0);
    chk("dr1_addr",  imem_addr, 32'h3014);
    chk("dr1_valid", 32'(validF), 0);
    tick;
    drive(1, 32'h4444_4180, 32'h4184, 0, 0, 0, 32'h0);
    chk("hdl_pc",    pcF, 32'h4180);
    chk("hdl_addr",  imem_addr, 32'h4180);
    chk("hdl_instr", instrF, 32'h4444_4180);
    tick;

    // trap+eret together with ack -> eret wins, no drain
    drive(1, 32'h5555_4184, 32'h4188, 0, 1, 1, 32'h3010);
    chk("te_flush", 32'(flushF), 1);
    chk("te_valid", 32'(validF), 0);
    tick;
    drive(0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    chk("te_pc",   pcF, 32'h3010);
    chk("te_addr", imem_addr, 32'h3010);
    tick;

    // eret then trap during DRAIN: latest redirect wins
    drive(0, 32'h0, 32'h0, 0, 0, 1, 32'h3020);
    chk("er_flush", 32'(flushF), 1);
    tick;
    drive(0, 32'h0, 32'h0, 0, 1, 0, 32'h0);
    chk("dr2_pc",   pcF, 32'h3020);
    chk("dr2_addr", imem_addr, 32'h3010);
    tick;
    drive(1, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    chk("dr3_pc",   pcF, 32'h4180);
    chk("dr3_addr", imem_addr, 32'h3010);
    tick;

    // misaligned and out-of-range PCs
    drive(1, 32'h6666_4180, 32'h3002, 0, 0, 0, 32'h0);
    chk("pre_valid", 32'(validF), 1);
    tick;
    drive(0, 32'h7777_7777, 32'h7000, 0, 0, 0, 32'h0);
    chk("mis_pc",    pcF, 32'h3002);
    chk("mis_req",   32'(imem_req), 0);
    chk("mis_addr",  imem_addr, 32'h0);
    chk("mis_valid", 32'(validF), 1);
    chk("mis_adel",  32'(adelF), 1);
    chk("mis_instr", instrF, 32'h0);
    tick;
    drive(0, 32'h0, 32'h3000, 1, 0, 0, 32'h0);
    chk("oor_pc",   pcF, 32'h7000);
    chk("oor_adel", 32'(adelF), 1);
    chk("oor_req",  32'(imem_req), 0);
    tick;
    drive(0, 32'h0, 32'h3000, 1, 1, 0, 32'h0);
    chk("oor_hold_pc", pcF, 32'h7000);
    chk("oor_tr_adel", 32'(adelF), 0);
    chk("oor_tr_val",  32'(validF), 0);
    tick;
    drive(1, 32'h8888_4180, 32'h6FFC, 0, 0, 0, 32'h0);
    chk("oor_hdl_pc",  pcF, 32'h4180);
    chk("oor_hdl_req", 32'(imem_req), 1);
    tick;

    // upper boundary legal, just below lower boundary illegal
    drive(1, 32'h9999_6FFC, 32'h2FFC, 0, 0, 0, 32'h0);
    chk("hi_addr", imem_addr, 32'h6FFC);
    chk("hi_adel", 32'(adelF), 0);
    chk("hi_val",  32'(validF), 1);
    tick;
    drive(0, 32'h0, 32'h4180, 0, 0, 0, 32'h0);
    chk("lo_adel", 32'(adelF), 1);
    chk("lo_req",  32'(imem_req), 0);
    tick;

    // reset mid-request
    drive(0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    chk("mr_req", 32'(imem_req), 1);
    tick;
    reset = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    chk("mr_rst_req", 32'(imem_req), 0);
    chk("mr_rst_val", 32'(validF), 0);
    tick;
    reset = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
    chk("mr_pc",   pcF, 32'h3000);
    chk("mr_req2", 32'(imem_req), 1);
    chk("mr_addr", imem_addr, 32'h3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
